// File: rtl/xnor_match_unit.sv
// rtl/xnor_match_unit.sv - registered XNOR word comparator with run detection and hit counting
//
// Optional feature macro: XNOR_MASK_EN
//   Defined:   a `mask` port and mask register exist. A mask bit of 0 excludes that bit from the match.
//   Undefined: there is no `mask` port, and every bit is compared.

module xnor_match_unit #(
  parameter int WIDTH   = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
`ifdef XNOR_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] eq_bits,
  output logic             match,
  output logic             found,
  output logic [CNT_W-1:0] hits
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FOUND = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pattern_q;
  logic [WIDTH-1:0] mask_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] eq_bits_q;
  logic             match_q;
  logic             found_q;
  logic [CNT_W-1:0] hits_q;
  logic [RUN_W-1:0] run_q;

  // Combinational compare results and the saturating next values for the counters.
  logic [WIDTH-1:0] eq_raw;
  logic             word_match;
  logic             armed;
  logic [CNT_W-1:0] hits_d;
  logic [RUN_W-1:0] run_d;

`ifndef XNOR_MASK_EN
  // Without masking, every bit always takes part in the compare.
  assign mask_q = {WIDTH{1'b1}};
`endif

  // Compare the incoming word against the stored pattern and precompute the counter increments.
  always_comb begin
    eq_raw     = ~(in_data ^ pattern_q);
    word_match = &(eq_raw | ~mask_q);
    armed      = (state_q != S_IDLE);
    hits_d     = (hits_q == HITS_MAX) ? hits_q : hits_q + CNT_W'(1);
    run_d      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
  end

  // State machine and registered outputs. Priority is reset, then load, then clear, then sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
`ifdef XNOR_MASK_EN
      mask_q      <= {WIDTH{1'b1}};
`endif
      out_valid_q <= 1'b0;
      eq_bits_q   <= '0;
      match_q     <= 1'b0;
      found_q     <= 1'b0;
      hits_q      <= '0;
      run_q       <= '0;
    end else if (load) begin
      // A new pattern re-arms the unit from any state. The sample in the same cycle is dropped.
      state_q     <= S_ARMED;
      pattern_q   <= pattern;
`ifdef XNOR_MASK_EN
      mask_q      <= mask;
`endif
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      hits_q      <= '0;
      run_q       <= '0;
    end else if (clear && armed) begin
      // Clear keeps the pattern but restarts the counting. The sample in the same cycle is dropped.
      state_q     <= S_ARMED;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      hits_q      <= '0;
      run_q       <= '0;
    end else if (in_valid && armed) begin
      out_valid_q <= 1'b1;
      eq_bits_q   <= eq_raw;
      match_q     <= word_match;
      if (word_match) begin
        hits_q <= hits_d;
        run_q  <= run_d;
        if (run_d == RUN_MAX) begin
          found_q <= 1'b1;
          state_q <= S_FOUND;
        end
      end else begin
        // A mismatch breaks the run. In FOUND, `found` remains set.
        run_q <= '0;
      end
    end else begin
      // With no accepted sample, eq_bits and match keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign eq_bits   = eq_bits_q;
  assign match     = match_q;
  assign found     = found_q;
  assign hits      = hits_q;

endmodule
